// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory data-port arbiter.
// Holds the arbiter state encoding, read-owner encoding and the word-size code.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_t;

  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
  localparam int         DMA_LEN_W     = 8;
  localparam int         DATA_W        = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU, DMA and memory data-port signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if #(
  parameter int AW = 32
) ();

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [1:0]    cpu_size;
  logic          cpu_sign;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [31:0]   cpu_rdata;

  logic          dma_start;
  logic          dma_we;
  logic [AW-1:0] dma_base;
  logic [7:0]    dma_len;
  logic [31:0]   dma_wdata;
  logic          dma_wready;
  logic          dma_rvalid;
  logic [31:0]   dma_rdata;
  logic          dma_busy;
  logic          dma_done;

  logic          mem_read2;
  logic          mem_write2;
  logic [AW-1:0] mem_addr2;
  logic [1:0]    mem_size;
  logic          mem_sign;
  logic [31:0]   mem_din2;
  logic [31:0]   mem_dout2;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_sign,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_start, dma_we, dma_base, dma_len, dma_wdata,
    output dma_wready, dma_rvalid, dma_rdata, dma_busy, dma_done,
    output mem_read2, mem_write2, mem_addr2, mem_size, mem_sign, mem_din2,
    input  mem_dout2
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_sign,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_start, dma_we, dma_base, dma_len, dma_wdata,
    input  dma_wready, dma_rvalid, dma_rdata, dma_busy, dma_done,
    input  mem_read2, mem_write2, mem_addr2, mem_size, mem_sign, mem_din2,
    output mem_dout2
  );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the DMA engine was denied the port.
// at_limit tells the arbiter to force the next DMA beat through.
module starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_atLimit
);

  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && !o_atLimit) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_atLimit = (r_count == W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory data port between the CPU MEM stage and a burst DMA engine.
// CPU has priority; a starved DMA burst gets one forced beat once the limit is reached.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32
) (
  input logic               CLK,
  input logic               RST,
  mem_port_arbiter_if.slave bus
);

  arb_state_t    r_state;
  arb_state_t    w_nextState;
  logic [AW-1:0] r_addrCnt;
  logic [7:0]    r_beatCnt;
  logic          r_dmaWe;
  logic          r_zeroDone;
  logic          r_rdPend;
  owner_t        r_owner;

  logic          w_atLimit;
  logic          w_inBurst;
  logic          w_dmaGrant;
  logic          w_cpuGrant;
  logic          w_lastBeat;
  logic          w_launch;
  logic          w_zeroStart;
  logic          w_readGrant;

  assign w_inBurst   = (r_state == BURST);
  assign w_dmaGrant  = w_inBurst && (!bus.cpu_req || w_atLimit);
  assign w_cpuGrant  = bus.cpu_req && !w_dmaGrant;
  assign w_lastBeat  = w_dmaGrant && (r_beatCnt == 8'd1);
  assign w_launch    = (r_state == IDLE) && bus.dma_start && (bus.dma_len != 8'd0);
  assign w_zeroStart = (r_state == IDLE) && bus.dma_start && (bus.dma_len == 8'd0);
  assign w_readGrant = (w_cpuGrant && !bus.cpu_we) || (w_dmaGrant && !r_dmaWe);

  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (CLK),
    .rst      (RST),
    .i_clear  (!w_inBurst || w_dmaGrant),
    .i_inc    (w_inBurst && !w_dmaGrant),
    .o_atLimit(w_atLimit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Burst bookkeeping plus the one-deep record of who owns the read returning next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addrCnt  <= '0;
      r_beatCnt  <= '0;
      r_dmaWe    <= 1'b0;
      r_zeroDone <= 1'b0;
      r_rdPend   <= 1'b0;
      r_owner    <= OWNER_CPU;
    end else begin
      r_zeroDone <= w_zeroStart;
      r_rdPend   <= w_readGrant;
      if (w_readGrant) begin
        r_owner <= w_dmaGrant ? OWNER_DMA : OWNER_CPU;
      end
      if (w_launch) begin
        r_addrCnt <= {bus.dma_base[AW-1:2], 2'b00};
        r_beatCnt <= bus.dma_len;
        r_dmaWe   <= bus.dma_we;
      end else if (w_dmaGrant) begin
        r_addrCnt <= r_addrCnt + AW'(4);
        r_beatCnt <= r_beatCnt - 8'd1;
      end
    end
  end

  always_comb begin
    w_nextState     = r_state;
    bus.mem_read2   = 1'b0;
    bus.mem_write2  = 1'b0;
    bus.mem_addr2   = '0;
    bus.mem_size    = 2'b00;
    bus.mem_sign    = 1'b0;
    bus.mem_din2    = '0;
    bus.dma_wready  = 1'b0;
    bus.cpu_stall   = bus.cpu_req && !w_cpuGrant;

    case (r_state)
      IDLE:    if (w_launch) w_nextState = BURST;
      BURST:   if (w_lastBeat) w_nextState = DRAIN;
      DRAIN:   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase

    if (w_cpuGrant) begin
      bus.mem_read2  = !bus.cpu_we;
      bus.mem_write2 = bus.cpu_we;
      bus.mem_addr2  = bus.cpu_addr;
      bus.mem_size   = bus.cpu_size;
      bus.mem_sign   = bus.cpu_sign;
      bus.mem_din2   = bus.cpu_we ? bus.cpu_wdata : '0;
    end else if (w_dmaGrant) begin
      bus.mem_read2  = !r_dmaWe;
      bus.mem_write2 = r_dmaWe;
      bus.mem_addr2  = r_addrCnt;
      bus.mem_size   = MEM_SIZE_WORD;
      bus.mem_sign   = 1'b0;
      bus.mem_din2   = r_dmaWe ? bus.dma_wdata : '0;
      bus.dma_wready = r_dmaWe;
    end
  end

  assign bus.cpu_rvalid = r_rdPend && (r_owner == OWNER_CPU);
  assign bus.dma_rvalid = r_rdPend && (r_owner == OWNER_DMA);
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_dout2 : '0;
  assign bus.dma_rdata  = bus.dma_rvalid ? bus.mem_dout2 : '0;
  assign bus.dma_busy   = (r_state != IDLE);
  assign bus.dma_done   = (r_state == DRAIN) || r_zeroDone;

endmodule
